dmem_responder: RTL

Responder end of the core's data-memory interface: accepts load/store requests issued by the `arm` datapath, serves them from an internal word array after a programmable number of wait states, and returns read data with a one-cycle `ready` pulse. It replaces the zero-latency data memory in the single-cycle top so that the core and its stall logic can be exercised against realistic memory timing. It supports word and byte accesses and flags misaligned or out-of-range accesses.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_mux.sv | 28 ++
 rtl/dmem_responder.sv | 111 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// access-size encodings and the byte-lane select used by the lane mux.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  // One-hot lane enable for a little-endian byte lane (lane 0 = bits 7:0).
  function automatic logic [3:0] laneSel(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/dmem_lane_mux.sv
// Combinational byte-lane logic: zero-extended byte extract for loads and
// lane-masked merge of store data into the existing word.
module dmem_lane_mux
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic        size,
  input  logic [31:0] wdata,
  output logic [31:0] loadData,
  output logic [31:0] storeData
);

  logic [3:0] byteEn;

  always_comb begin
    byteEn    = (size == SIZE_BYTE) ? laneSel(lane) : 4'b1111;
    loadData  = (size == SIZE_BYTE) ? {24'h0, word[{lane, 3'b000} +: 8]} : word;
    storeData = word;
    for (int i = 0; i < 4; i++) begin
      if (byteEn[i]) begin
        // Byte stores replicate wdata[7:0]; only the enabled lane takes it.
        storeData[8*i +: 8] = (size == SIZE_BYTE) ? wdata[7:0] : wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT_CYCLES
// wait states, then returns registered rdata/err with a one-cycle ready pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output dmem_state_t dbgState
);

  // Handshake: req is sampled only in IDLE and a high req there accepts one
  // access; the requester holds req until then. ready is a one-cycle
  // completion pulse and rdata/err are meaningful only while ready is high.

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  dmem_state_t state, nextState;
  logic [3:0]  cnt;
  logic        reqWe, reqSize;
  logic [31:0] reqAddr, reqWdata;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, enterResp, fault;
  logic        curWe, curSize;
  logic [31:0] curAddr, curWdata;
  logic [31:0] memWord, loadData, storeData;

  // In IDLE the live inputs drive the datapath so WAIT_CYCLES = 0 can respond
  // straight away; afterwards the latched request does.
  assign curWe    = (state == IDLE) ? we    : reqWe;
  assign curSize  = (state == IDLE) ? size  : reqSize;
  assign curAddr  = (state == IDLE) ? addr  : reqAddr;
  assign curWdata = (state == IDLE) ? wdata : reqWdata;

  assign accept    = (state == IDLE) && req;
  assign enterResp = (nextState == RESP) && (state != RESP);
  assign fault     = ((curSize == SIZE_WORD) && (curAddr[1:0] != 2'b00)) ||
                     ({2'b00, curAddr[31:2]} >= 32'(DEPTH_WORDS));
  assign memWord   = mem[curAddr[AW+1:2]];
  assign dbgState  = state;

  dmem_lane_mux u_laneMux (
    .word      (memWord),
    .lane      (curAddr[1:0]),
    .size      (curSize),
    .wdata     (curWdata),
    .loadData  (loadData),
    .storeData (storeData)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (req) nextState = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      reqWe    <= 1'b0;
      reqSize  <= SIZE_WORD;
      reqAddr  <= 32'h0;
      reqWdata <= 32'h0;
      ready    <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      rdata    <= 32'h0;
    end else begin
      state <= nextState;
      if (accept) begin
        reqWe    <= we;
        reqSize  <= size;
        reqAddr  <= addr;
        reqWdata <= wdata;
        cnt      <= WAIT_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      ready <= enterResp;
      err   <= enterResp && fault;
      rdata <= (enterResp && !curWe && !fault) ? loadData : 32'h0;
      busy  <= (nextState != IDLE);
    end
  end

  // Array is never reset; a store commits on the edge that ends RESP.
  always_ff @(posedge clk) begin
    if (!rst && (state == RESP) && curWe && !fault) begin
      mem[curAddr[AW+1:2]] <= storeData;
    end
  end

endmodule
